// File: rtl/mem_dp_reg.sv
// mem_dp_reg: parametrised simple-dual-port memory with a registered read port, read-valid/error flags and an occupancy count.
// Define MEM_DP_BYPASS_EN for write-first same-address reads; the default build is read-first.
module mem_dp_reg #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      written;
  logic                  wr_ok;
  logic                  rd_in;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_data_nx;
  logic                  rd_err_nx;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in = ({1'b0, rd_addr} < DEPTH_W);
  assign full  = (fill_count == DEPTH_W);

  always_comb begin
    rd_hit     = rd_in && written[rd_addr];
    rd_data_nx = rd_hit ? mem[rd_addr] : '0;
    rd_err_nx  = !rd_hit;
`ifdef MEM_DP_BYPASS_EN
    // Same-address write wins: forward the incoming word, even into an unwritten entry
    if (wr_ok && rd_in && (wr_addr == rd_addr)) begin
      rd_data_nx = wr_data;
      rd_err_nx  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read stage boundary: registered read data and qualifiers, one cycle after rd_en
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      written    <= '0;
      fill_count <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      if (wr_ok) begin
        written[wr_addr] <= 1'b1;
        if (!written[wr_addr]) fill_count <= fill_count + 1'b1;
      end
      rd_valid <= rd_en;
      rd_err   <= rd_en & rd_err_nx;
      if (rd_en) rd_data <= rd_data_nx;
    end
  end

endmodule

// File: tb/tb_mem_dp_reg.sv
// Directed self-checking bench for mem_dp_reg: an 8-deep and a 5-deep instance sharing clock and reset.
module tb_mem_dp_reg;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;

  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [2:0] wr_addr = '0, rd_addr = '0;
  logic [5:0] wr_data = '0;
  logic [5:0] rd_data;
  logic       rd_valid, rd_err, full;
  logic [3:0] fill_count;

  logic       wr_en5 = 1'b0, rd_en5 = 1'b0;
  logic [2:0] wr_addr5 = '0, rd_addr5 = '0;
  logic [5:0] wr_data5 = '0;
  logic [5:0] rd_data5;
  logic       rd_valid5, rd_err5, full5;
  logic [3:0] fill_count5;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_dp_reg #(.DATA_WIDTH(6), .DEPTH(8)) u_dut (
    .clk(clk), .RESET(RESET),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .fill_count(fill_count), .full(full)
  );

  mem_dp_reg #(.DATA_WIDTH(6), .DEPTH(5)) u_dut5 (
    .clk(clk), .RESET(RESET),
    .wr_en(wr_en5), .wr_addr(wr_addr5), .wr_data(wr_data5),
    .rd_en(rd_en5), .rd_addr(rd_addr5),
    .rd_data(rd_data5), .rd_valid(rd_valid5), .rd_err(rd_err5),
    .fill_count(fill_count5), .full(full5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_read(input string tag, input logic [5:0] d, input logic v, input logic e);
    check({tag, " rd_data"}, 32'(rd_data), 32'(d));
    check({tag, " rd_valid"}, 32'(rd_valid), 32'(v));
    check({tag, " rd_err"}, 32'(rd_err), 32'(e));
  endtask

  initial begin
    // reset held across two edges
    tick();
    tick();
    check_read("reset", 6'h00, 1'b0, 1'b0);
    check("reset fill_count", 32'(fill_count), 32'd0);
    check("reset full", 32'(full), 32'd0);
    RESET = 1'b0;

    // read of an unwritten entry
    rd_en = 1'b1; rd_addr = 3'd3;
    tick();
    check_read("unwritten rd3", 6'h00, 1'b1, 1'b1);
    check("unwritten fill_count", 32'(fill_count), 32'd0);
    rd_en = 1'b0;

    // fill all eight entries
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 6'(i + 1);
      tick();
      check($sformatf("fill_count after wr%0d", i), 32'(fill_count), 32'(i + 1));
      check($sformatf("full after wr%0d", i), 32'(full), (i == 7) ? 32'd1 : 32'd0);
      if (i == 0) check("idle rd_valid", 32'(rd_valid), 32'd0);
    end
    wr_en = 1'b0;

    // back-to-back reads
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; rd_addr = 3'(i);
      tick();
      check_read($sformatf("b2b rd%0d", i), 6'(i + 1), 1'b1, 1'b0);
    end
    rd_en = 1'b0;
    tick();
    check_read("hold after rd", 6'h08, 1'b0, 1'b0);

    // rewrites do not change occupancy
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 6'h0C;
    tick();
    wr_addr = 3'd5; wr_data = 6'h0B;
    tick();
    wr_en = 1'b0;
    check("rewrite fill_count", 32'(fill_count), 32'd8);
    check("rewrite full", 32'(full), 32'd1);
    rd_en = 1'b1; rd_addr = 3'd1;
    tick();
    check_read("rewrite rd1", 6'h0C, 1'b1, 1'b0);
    rd_addr = 3'd5;
    tick();
    check_read("rewrite rd5", 6'h0B, 1'b1, 1'b0);

    // reset mid-stream: rd_valid drops as soon as RESET rises
    rd_addr = 3'd2;
    tick();
    check_read("pre-reset rd2", 6'h03, 1'b1, 1'b0);
    rd_addr = 3'd3;
    #2;
    RESET = 1'b1;
    #1;
    check("async reset rd_valid", 32'(rd_valid), 32'd0);
    check("async reset fill_count", 32'(fill_count), 32'd0);
    check("async reset full", 32'(full), 32'd0);
    tick();
    check("reset cycle rd_valid", 32'(rd_valid), 32'd0);
    RESET = 1'b0;
    rd_addr = 3'd2;
    tick();
    check_read("post-reset rd2", 6'h00, 1'b1, 1'b1);
    rd_addr = 3'd7;
    tick();
    check_read("post-reset rd7", 6'h00, 1'b1, 1'b1);
    check("post-reset fill_count", 32'(fill_count), 32'd0);
    rd_en = 1'b0;

    // same-edge write and read of the same unwritten address
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 6'h2A;
    rd_en = 1'b1; rd_addr = 3'd2;
    tick();
`ifdef MEM_DP_BYPASS_EN
    check_read("same-addr rw", 6'h2A, 1'b1, 1'b0);
`else
    check_read("same-addr rw", 6'h00, 1'b1, 1'b1);
`endif
    check("same-addr fill_count", 32'(fill_count), 32'd1);
    wr_en = 1'b0;
    tick();
    check_read("same-addr followup rd2", 6'h2A, 1'b1, 1'b0);

    // simultaneous write and read at different addresses
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 6'h15;
    rd_addr = 3'd2;
    tick();
    check_read("diff-addr rw rd2", 6'h2A, 1'b1, 1'b0);
    wr_en = 1'b0; rd_addr = 3'd6;
    tick();
    check_read("diff-addr followup rd6", 6'h15, 1'b1, 1'b0);
    check("diff-addr fill_count", 32'(fill_count), 32'd2);
    rd_en = 1'b0;

    // DEPTH=5 instance: out-of-range write dropped, out-of-range read errors
    wr_en5 = 1'b1; wr_addr5 = 3'd6; wr_data5 = 6'h33;
    tick();
    check("d5 oor wr fill_count", 32'(fill_count5), 32'd0);
    wr_en5 = 1'b0;
    rd_en5 = 1'b1; rd_addr5 = 3'd6;
    tick();
    check("d5 oor rd_data", 32'(rd_data5), 32'd0);
    check("d5 oor rd_valid", 32'(rd_valid5), 32'd1);
    check("d5 oor rd_err", 32'(rd_err5), 32'd1);
    rd_en5 = 1'b0;
    wr_en5 = 1'b1; wr_addr5 = 3'd4; wr_data5 = 6'h3F;
    tick();
    wr_en5 = 1'b0;
    check("d5 top wr fill_count", 32'(fill_count5), 32'd1);
    check("d5 top wr full", 32'(full5), 32'd0);
    rd_en5 = 1'b1; rd_addr5 = 3'd4;
    tick();
    check("d5 top rd_data", 32'(rd_data5), 32'h3F);
    check("d5 top rd_err", 32'(rd_err5), 32'd0);
    rd_en5 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
